memory_stage: RTL and testbench

- Pipeline MEM stage: EX/MEM register plus a byte-addressable data memory with configurable wait states.
- Sits directly upstream of the MEM/WB writeback register. Drives that register's ALUOutM/DMOut/rtdM/RFWEM/MtoRFSelM/JumpM inputs.
- Stalls the front of the pipe while a memory access is pending.
- Supports byte, half and word loads/stores with sign or zero extension and misalignment detection.

---
 rtl/memory_stage_if.sv | 31 +++
 rtl/memory_stage.sv | 122 ++++++++++++
 tb/tb_memory_stage.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// EX->MEM boundary bundle: E-side instruction fields in, M-side results out toward MEM/WB.
interface memory_stage_if;
  logic [31:0] ALUOutE;
  logic [31:0] WriteDataE;
  logic [4:0]  rtdE;
  logic        RFWEE;
  logic        MtoRFSelE;
  logic        DMWEE;
  logic        JumpE;
  logic [1:0]  SizeE;
  logic        SignedE;

  logic [31:0] ALUOutM;
  logic [31:0] DMOut;
  logic [4:0]  rtdM;
  logic        RFWEM;
  logic        MtoRFSelM;
  logic        JumpM;
  logic        StallM;
  logic        MisalignM;

  modport master (
    output ALUOutE, WriteDataE, rtdE, RFWEE, MtoRFSelE, DMWEE, JumpE, SizeE, SignedE,
    input  ALUOutM, DMOut, rtdM, RFWEM, MtoRFSelM, JumpM, StallM, MisalignM
  );

  modport slave (
    input  ALUOutE, WriteDataE, rtdE, RFWEE, MtoRFSelE, DMWEE, JumpE, SizeE, SignedE,
    output ALUOutM, DMOut, rtdM, RFWEM, MtoRFSelM, JumpM, StallM, MisalignM
  );
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register plus byte-addressable data memory with MEM_LAT wait states.
module memory_stage #(
  parameter int ADDR_BITS = 10,
  parameter int MEM_LAT   = 2
) (
  input  logic           CLK,
  input  logic           RSTn,
  memory_stage_if.slave  bus
);
  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT   = 4'(MEM_LAT);

  logic [31:0] alu_q, wdata_q;
  logic [4:0]  rtd_q;
  logic        rfwe_q, mtorf_q, dmwe_q, jump_q, sgn_q;
  logic [1:0]  size_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem [DEPTH];

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    h  = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  logic stall, misal_m, active;
  assign stall   = cnt_q != 4'd0;
  assign misal_m = (mtorf_q | dmwe_q) & misaligned(size_q, alu_q[1:0]);
  assign active  = !stall && !misal_m;

  // Only aligned memory ops occupy the slot for the extra wait states.
  always_comb begin
    cnt_d = 4'd0;
    if (stall)
      cnt_d = cnt_q - 4'd1;
    else if ((bus.MtoRFSelE | bus.DMWEE) && !misaligned(bus.SizeE, bus.ALUOutE[1:0]))
      cnt_d = LAT;
  end

  // EX/MEM register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      alu_q   <= '0;
      wdata_q <= '0;
      rtd_q   <= '0;
      rfwe_q  <= 1'b0;
      mtorf_q <= 1'b0;
      dmwe_q  <= 1'b0;
      jump_q  <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) begin
        alu_q   <= bus.ALUOutE;
        wdata_q <= bus.WriteDataE;
        rtd_q   <= bus.rtdE;
        rfwe_q  <= bus.RFWEE;
        mtorf_q <= bus.MtoRFSelE;
        dmwe_q  <= bus.DMWEE;
        jump_q  <= bus.JumpE;
        size_q  <= bus.SizeE;
        sgn_q   <= bus.SignedE;
      end
    end
  end

  logic [ADDR_BITS-1:0] widx;
  logic [3:0]           be;
  logic [31:0]          wword;
  assign widx = alu_q[ADDR_BITS+1:2];

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = 4'b1111;
    wword = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << alu_q[1:0];
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = alu_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Data memory (not reset)
  always_ff @(posedge CLK) begin
    if (dmwe_q && active) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  assign bus.ALUOutM   = alu_q;
  assign bus.rtdM      = rtd_q;
  assign bus.MtoRFSelM = mtorf_q;
  assign bus.RFWEM     = rfwe_q & active;
  assign bus.JumpM     = jump_q & !stall;
  assign bus.StallM    = stall;
  assign bus.MisalignM = misal_m;
  assign bus.DMOut     = (mtorf_q && active) ? load_ext(mem[widx], size_q, alu_q[1:0], sgn_q) : 32'd0;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a MEM_LAT=2 instance for timing/memory ops, a MEM_LAT=0 instance for back-to-back flow.
module tb_memory_stage;
  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  memory_stage_if bus();
  memory_stage_if bf();

  memory_stage #(.ADDR_BITS(10), .MEM_LAT(2)) dut  (.CLK(CLK), .RSTn(RSTn), .bus(bus));
  memory_stage #(.ADDR_BITS(10), .MEM_LAT(0)) dut0 (.CLK(CLK), .RSTn(RSTn), .bus(bf));

  typedef struct {
    logic [31:0] a, wd;
    logic [4:0]  rd;
    logic        rfwe, ld, st, jmp;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] dm;
    logic        mis;
    int          stalls;
  } op_t;

  typedef struct {
    logic [72:0] v;
    int          stalls;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  function automatic op_t mk(input logic [31:0] a, wd, input logic [4:0] rd,
                             input logic rfwe, ld, st, jmp, input logic [1:0] sz,
                             input logic sg, input logic [31:0] dm, input logic mis);
    op_t o;
    o.a = a; o.wd = wd; o.rd = rd; o.rfwe = rfwe; o.ld = ld; o.st = st; o.jmp = jmp;
    o.sz = sz; o.sg = sg; o.dm = mis ? 32'd0 : dm; o.mis = mis;
    o.stalls = ((ld | st) && !mis) ? 2 : 0;
    return o;
  endfunction

  function automatic op_t SW(input logic [31:0] a, d, input logic [1:0] sz, input logic mis);
    return mk(a, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, sz, 1'b0, 32'd0, mis);
  endfunction

  function automatic op_t LD(input logic [31:0] a, input logic [4:0] rd, input logic [1:0] sz,
                             input logic sg, input logic [31:0] dm, input logic mis);
    return mk(a, 32'd0, rd, 1'b1, 1'b1, 1'b0, 1'b0, sz, sg, dm, mis);
  endfunction

  // Expected M-side vector: ALUOutM, DMOut, rtdM, RFWEM, MtoRFSelM, JumpM, MisalignM
  function automatic logic [72:0] expv(input op_t o);
    return {o.a, o.dm, o.rd, o.rfwe & ~o.mis, o.ld, o.jmp, o.mis};
  endfunction

  function automatic logic [72:0] obs2();
    return {bus.ALUOutM, bus.DMOut, bus.rtdM, bus.RFWEM, bus.MtoRFSelM, bus.JumpM, bus.MisalignM};
  endfunction

  function automatic logic [72:0] obs0();
    return {bf.ALUOutM, bf.DMOut, bf.rtdM, bf.RFWEM, bf.MtoRFSelM, bf.JumpM, bf.MisalignM};
  endfunction

  task automatic set_bubble();
    bus.ALUOutE = '0; bus.WriteDataE = '0; bus.rtdE = '0; bus.RFWEE = 0; bus.MtoRFSelE = 0;
    bus.DMWEE = 0; bus.JumpE = 0; bus.SizeE = 2'b10; bus.SignedE = 0;
    bf.ALUOutE = '0; bf.WriteDataE = '0; bf.rtdE = '0; bf.RFWEE = 0; bf.MtoRFSelE = 0;
    bf.DMWEE = 0; bf.JumpE = 0; bf.SizeE = 2'b10; bf.SignedE = 0;
  endtask

  task automatic drive2(input op_t o);
    bus.ALUOutE = o.a; bus.WriteDataE = o.wd; bus.rtdE = o.rd; bus.RFWEE = o.rfwe;
    bus.MtoRFSelE = o.ld; bus.DMWEE = o.st; bus.JumpE = o.jmp; bus.SizeE = o.sz; bus.SignedE = o.sg;
  endtask

  task automatic drive0(input op_t o);
    bf.ALUOutE = o.a; bf.WriteDataE = o.wd; bf.rtdE = o.rd; bf.RFWEE = o.rfwe;
    bf.MtoRFSelE = o.ld; bf.DMWEE = o.st; bf.JumpE = o.jmp; bf.SizeE = o.sz; bf.SignedE = o.sg;
  endtask

  // Called at a negedge with the slot free; returns at the negedge of the op's result cycle.
  task automatic issue(input op_t o, output int stalls, output logic leak);
    drive2(o);
    @(posedge CLK);
    @(negedge CLK);
    set_bubble();
    stalls = 0;
    leak   = 1'b0;
    while (bus.StallM === 1'b1 && stalls < 40) begin
      if (bus.RFWEM !== 1'b0 || bus.JumpM !== 1'b0 || bus.DMOut !== 32'd0) leak = 1'b1;
      stalls++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    set_bubble();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if ({obs2(), bus.StallM} !== 74'd0) begin
      bad++; $display("FAIL reset_lat2 got=%h want=0", {obs2(), bus.StallM});
    end
    total++;
    if ({obs0(), bf.StallM} !== 74'd0) begin
      bad++; $display("FAIL reset_lat0 got=%h want=0", {obs0(), bf.StallM});
    end
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int st; logic lk;
    drive2(SW(32'h10, 32'hDEADBEEF, 2'b10, 1'b0));
    @(posedge CLK);
    @(negedge CLK);
    set_bubble();
    @(posedge CLK);
    #2;
    total++;
    if (bus.StallM !== 1'b1) begin
      bad++; $display("FAIL rstmid_stall_before got=%b want=1", bus.StallM);
    end
    RSTn = 1'b0;
    #1;
    total++;
    if ({obs2(), bus.StallM} !== 74'd0) begin
      bad++; $display("FAIL rstmid_async_clear got=%h want=0", {obs2(), bus.StallM});
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    issue(LD(32'h10, 5'd8, 2'b10, 1'b0, 32'd0, 1'b0), st, lk);
    total++;
    if (bus.DMOut === 32'hDEADBEEF) begin
      bad++; $display("FAIL rstmid_store_dropped got=%h want=not deadbeef", bus.DMOut);
    end
    total++;
    if (st !== 2 || bus.RFWEM !== 1'b1) begin
      bad++; $display("FAIL rstmid_lw_after got stalls=%0d rfwe=%b want stalls=2 rfwe=1", st, bus.RFWEM);
    end
  endtask

  task automatic test_word_timing();
    op_t ops[$]; exp_t e; int st; logic lk;
    ops.push_back(SW(32'h10, 32'hDEADBEEF, 2'b10, 1'b0));
    ops.push_back(LD(32'h10, 5'd8, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0));
    foreach (ops[i]) begin
      sbq.push_back('{v: expv(ops[i]), stalls: ops[i].stalls});
      issue(ops[i], st, lk);
      e = sbq.pop_front();
      total++;
      if (obs2() !== e.v) begin
        bad++; $display("FAIL word[%0d] result got=%h want=%h", i, obs2(), e.v);
      end
      total++;
      if (st !== e.stalls || lk) begin
        bad++; $display("FAIL word[%0d] stall got=%0d leak=%b want=%0d leak=0", i, st, lk, e.stalls);
      end
    end
  endtask

  task automatic test_extension();
    op_t ops[$]; exp_t e; int st; logic lk;
    ops.push_back(SW(32'h20, 32'h80FF7F01, 2'b10, 1'b0));
    ops.push_back(LD(32'h23, 5'd1, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0));
    ops.push_back(LD(32'h23, 5'd2, 2'b00, 1'b0, 32'h00000080, 1'b0));
    ops.push_back(LD(32'h22, 5'd3, 2'b01, 1'b1, 32'hFFFF80FF, 1'b0));
    ops.push_back(LD(32'h20, 5'd4, 2'b01, 1'b0, 32'h00007F01, 1'b0));
    foreach (ops[i]) begin
      sbq.push_back('{v: expv(ops[i]), stalls: ops[i].stalls});
      issue(ops[i], st, lk);
      e = sbq.pop_front();
      total++;
      if (obs2() !== e.v) begin
        bad++; $display("FAIL ext[%0d] result got=%h want=%h", i, obs2(), e.v);
      end
      total++;
      if (st !== e.stalls || lk) begin
        bad++; $display("FAIL ext[%0d] stall got=%0d leak=%b want=%0d leak=0", i, st, lk, e.stalls);
      end
    end
  endtask

  task automatic test_partial_store();
    op_t ops[$]; exp_t e; int st; logic lk;
    ops.push_back(SW(32'h30, 32'h11223344, 2'b10, 1'b0));
    ops.push_back(SW(32'h31, 32'h000000AA, 2'b00, 1'b0));
    ops.push_back(LD(32'h30, 5'd6, 2'b10, 1'b0, 32'h1122AA44, 1'b0));
    ops.push_back(SW(32'h32, 32'h0000BEEF, 2'b01, 1'b0));
    ops.push_back(LD(32'h30, 5'd6, 2'b10, 1'b0, 32'hBEEFAA44, 1'b0));
    foreach (ops[i]) begin
      sbq.push_back('{v: expv(ops[i]), stalls: ops[i].stalls});
      issue(ops[i], st, lk);
      e = sbq.pop_front();
      total++;
      if (obs2() !== e.v) begin
        bad++; $display("FAIL partial[%0d] result got=%h want=%h", i, obs2(), e.v);
      end
      total++;
      if (st !== e.stalls || lk) begin
        bad++; $display("FAIL partial[%0d] stall got=%0d leak=%b want=%0d leak=0", i, st, lk, e.stalls);
      end
    end
  endtask

  task automatic test_misalign();
    op_t ops[$]; exp_t e; int st; logic lk;
    ops.push_back(SW(32'h34, 32'hCAFEF00D, 2'b10, 1'b0));
    ops.push_back(SW(32'h35, 32'h12345678, 2'b10, 1'b1));
    ops.push_back(LD(32'h34, 5'd7, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0));
    ops.push_back(LD(32'h33, 5'd5, 2'b01, 1'b1, 32'd0, 1'b1));
    foreach (ops[i]) begin
      sbq.push_back('{v: expv(ops[i]), stalls: ops[i].stalls});
      issue(ops[i], st, lk);
      e = sbq.pop_front();
      total++;
      if (obs2() !== e.v) begin
        bad++; $display("FAIL misalign[%0d] result got=%h want=%h", i, obs2(), e.v);
      end
      total++;
      if (st !== e.stalls || lk) begin
        bad++; $display("FAIL misalign[%0d] stall got=%0d leak=%b want=%0d leak=0", i, st, lk, e.stalls);
      end
    end
  endtask

  task automatic test_passthrough_wrap();
    op_t ops[$]; exp_t e; int st; logic lk;
    ops.push_back(mk(32'h64, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 1'b0));
    ops.push_back(mk(32'h1234, 32'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0));
    ops.push_back(SW(32'h1000, 32'hA5A55A5A, 2'b10, 1'b0));
    ops.push_back(LD(32'h0000, 5'd10, 2'b10, 1'b0, 32'hA5A55A5A, 1'b0));
    foreach (ops[i]) begin
      sbq.push_back('{v: expv(ops[i]), stalls: ops[i].stalls});
      issue(ops[i], st, lk);
      e = sbq.pop_front();
      total++;
      if (obs2() !== e.v) begin
        bad++; $display("FAIL pass_wrap[%0d] result got=%h want=%h", i, obs2(), e.v);
      end
      total++;
      if (st !== e.stalls || lk) begin
        bad++; $display("FAIL pass_wrap[%0d] stall got=%0d leak=%b want=%0d leak=0", i, st, lk, e.stalls);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$]; exp_t e;
    ops.push_back(mk(32'h64, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 1'b0));
    ops.push_back(SW(32'h40, 32'h13579BDF, 2'b10, 1'b0));
    ops.push_back(LD(32'h40, 5'd9, 2'b10, 1'b0, 32'h13579BDF, 1'b0));
    ops.push_back(LD(32'h43, 5'd11, 2'b00, 1'b1, 32'h00000013, 1'b0));
    ops.push_back(SW(32'h42, 32'h0000FFFF, 2'b01, 1'b0));
    ops.push_back(LD(32'h42, 5'd12, 2'b01, 1'b1, 32'hFFFFFFFF, 1'b0));
    ops.push_back(mk(32'h1234, 32'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0));
    foreach (ops[i]) begin
      drive0(ops[i]);
      sbq.push_back('{v: expv(ops[i]), stalls: 0});
      @(posedge CLK);
      @(negedge CLK);
      e = sbq.pop_front();
      total++;
      if (obs0() !== e.v) begin
        bad++; $display("FAIL b2b[%0d] result got=%h want=%h", i, obs0(), e.v);
      end
      total++;
      if (bf.StallM !== 1'b0) begin
        bad++; $display("FAIL b2b[%0d] stall got=%b want=0", i, bf.StallM);
      end
    end
    set_bubble();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_word_timing();
    test_extension();
    test_partial_store();
    test_misalign();
    test_passthrough_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
